// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule engine and cipher datapath.
//   state_e    : key-expansion FSM states
//   RCON_INIT  : first round constant
//   xtime      : multiply by x in GF(2^8), reduction polynomial 0x11b
//   nwords     : number of round-key words for a key of nk 32-bit words
//   rot_word   : rotate a 32-bit word left by one byte
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_FIN
    } state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int unsigned nwords(input int unsigned nk);
        return 4 * (nk + 7);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
//   byte_i : input byte
//   byte_o : substituted byte
module aes_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Element 0 sits in the most significant byte of the concatenation.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES key-schedule engine (AES-128/192/256 selected by NK).
// Streams w[0..4*(NK+7)-1], one word per valid/ready transfer.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin expansion (sampled only when idle)
//   key_in     : cipher key, w[0] in the top 32 bits
//   busy       : expansion in progress
//   w_valid    : w_data/w_index hold a word
//   w_ready    : downstream accepts the word
//   w_data     : round-key word, byte 0 in bits [31:24]
//   w_index    : index of w_data
//   done       : one-cycle pulse after the last transfer
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int unsigned NK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [32*NK-1:0]  key_in,
    output logic              busy,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [31:0]       w_data,
    output logic [5:0]        w_index,
    output logic              done
);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_key_expand: NK must be 4, 6 or 8");
    end

    localparam logic [5:0] LAST_IDX = 6'(nwords(NK) - 1);
    localparam logic [5:0] KEY_LAST = 6'(NK - 1);

    state_e               state_q, state_d;
    logic [NK-1:0][31:0]  win_q, win_d;     // index 0 = oldest word
    logic [7:0]           rcon_q, rcon_d;
    logic [5:0]           idx_q, idx_d;
    logic [31:0]          w_data_q, w_data_d;
    logic                 w_valid_q, w_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 xfer;
    logic [5:0]           nidx;
    logic [5:0]           nmod;
    logic [5:0]           cmod;
    logic [31:0]          prev_w;
    logic [31:0]          old_w;
    logic [31:0]          load_w;
    logic [31:0]          sub_in;
    logic [31:0]          sub_out;
    logic [31:0]          temp_w;
    logic [31:0]          next_w;

    assign xfer = w_valid_q & w_ready;
    assign nidx = idx_q + 6'd1;
    assign nmod = nidx % 6'(NK);
    assign cmod = idx_q % 6'(NK);

    // The next word w[nidx] is built from w[nidx-1] and w[nidx-NK].
    // During LOAD the window still holds w[0..NK-1] unshifted, so both
    // operands come from the window; in EXPAND the window holds
    // w[idx-NK..idx-1] and the presented word w[idx] is prev.
    always_comb begin
        if (state_q == ST_LOAD) begin
            prev_w = win_q[NK-1];
            old_w  = win_q[0];
        end else begin
            prev_w = w_data_q;
            old_w  = win_q[1];
        end
    end

    always_comb begin
        load_w = '0;
        for (int unsigned j = 0; j < NK; j++) begin
            if (nidx == 6'(j)) begin
                load_w = win_q[j];
            end
        end
    end

    // Single SubWord path shared by the rcon words and the AES-256 mid-key word.
    assign sub_in = (nmod == '0) ? rot_word(prev_w) : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_i (sub_in[8*b +: 8]),
            .byte_o (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        if (nmod == '0) begin
            temp_w = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && nmod == 6'd4) begin
            temp_w = sub_out;
        end else begin
            temp_w = prev_w;
        end
        next_w = old_w ^ temp_w;
    end

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        rcon_d    = rcon_q;
        idx_d     = idx_q;
        w_data_d  = w_data_q;
        w_valid_d = w_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int unsigned j = 0; j < NK; j++) begin
                        win_d[j] = key_in[32*(NK-j)-1 -: 32];
                    end
                    rcon_d    = RCON_INIT;
                    idx_d     = '0;
                    w_data_d  = key_in[32*NK-1 -: 32];
                    w_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    idx_d = nidx;
                    if (idx_q == KEY_LAST) begin
                        w_data_d = next_w;
                        state_d  = ST_EXPAND;
                    end else begin
                        w_data_d = load_w;
                    end
                end
            end
            ST_EXPAND: begin
                if (xfer) begin
                    if (cmod == '0) begin
                        rcon_d = xtime(rcon_q);
                    end
                    win_d = {w_data_q, win_q[NK-1:1]};
                    if (idx_q == LAST_IDX) begin
                        w_valid_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_FIN;
                    end else begin
                        w_data_d = next_w;
                        idx_d    = nidx;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            rcon_q    <= RCON_INIT;
            idx_q     <= '0;
            w_data_q  <= '0;
            w_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            rcon_q    <= rcon_d;
            idx_q     <= idx_d;
            w_data_q  <= w_data_d;
            w_valid_q <= w_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign w_valid = w_valid_q;
    assign w_data  = w_data_q;
    assign w_index = idx_q;
    assign done    = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand with NK = 4, 6 and 8 instances.
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]         start_v;
    logic [2:0]         rdy_v;
    logic [2:0][255:0]  key_v;
    logic [2:0]         busy_v;
    logic [2:0]         valid_v;
    logic [2:0]         done_v;
    logic [2:0][31:0]   data_v;
    logic [2:0][5:0]    idx_v;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] exp_w [60];
    logic [31:0] got_w [60];

    aes_key_expand #(.NK(4)) u_nk4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .key_in(key_v[0][255 -: 128]),
        .busy(busy_v[0]), .w_valid(valid_v[0]), .w_ready(rdy_v[0]),
        .w_data(data_v[0]), .w_index(idx_v[0]), .done(done_v[0])
    );

    aes_key_expand #(.NK(6)) u_nk6 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .key_in(key_v[1][255 -: 192]),
        .busy(busy_v[1]), .w_valid(valid_v[1]), .w_ready(rdy_v[1]),
        .w_data(data_v[1]), .w_index(idx_v[1]), .done(done_v[1])
    );

    aes_key_expand #(.NK(8)) u_nk8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .key_in(key_v[2]),
        .busy(busy_v[2]), .w_valid(valid_v[2]), .w_ready(rdy_v[2]),
        .w_data(data_v[2]), .w_index(idx_v[2]), .done(done_v[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_total++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Reference S-box from its algebraic definition: inverse in GF(2^8)
    // followed by the affine transform.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] sq = x;
        logic [7:0] r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] ref_subword(input logic [31:0] w);
        return {ref_sbox(w[31:24]), ref_sbox(w[23:16]), ref_sbox(w[15:8]), ref_sbox(w[7:0])};
    endfunction

    task automatic build_model(input int nk, input logic [255:0] key);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < nk; i++) exp_w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = exp_w[i-1];
            if (i % nk == 0) begin
                t  = ref_subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                t = ref_subword(t);
            end
            exp_w[i] = exp_w[i-nk] ^ t;
        end
    endtask

    task automatic run_stream(input int u, input int nk, input logic [255:0] key,
                              input bit throttle, input bit poke_start, input int reset_at);
        int  n   = 4*(nk+7);
        int  k   = 0;
        int  cyc = 0;
        bit  fin = 0;
        bit  rdy;
        build_model(nk, key);
        for (int i = 0; i < 60; i++) got_w[i] = '0;
        key_v[u]   = key;
        rdy_v[u]   = 1'b1;
        start_v[u] = 1'b1;
        @(posedge clk); #1;
        start_v[u] = 1'b0;
        key_v[u]   = ~key;
        check($sformatf("nk%0d_start_busy", nk), 64'(busy_v[u]), 64'd1);
        while (!fin && cyc < 1000) begin
            if (k < n) begin
                check($sformatf("nk%0d_valid@%0d", nk, k), 64'(valid_v[u]), 64'd1);
                check($sformatf("nk%0d_index@%0d", nk, k), 64'(idx_v[u]), 64'(k));
                check($sformatf("nk%0d_w[%0d]", nk, k), 64'(data_v[u]), 64'(exp_w[k]));
                got_w[k] = data_v[u];
                if (reset_at == k) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_busy",  64'(busy_v[u]),  64'd0);
                    check("rst_valid", 64'(valid_v[u]), 64'd0);
                    check("rst_done",  64'(done_v[u]),  64'd0);
                    check("rst_data",  64'(data_v[u]),  64'd0);
                    check("rst_index", 64'(idx_v[u]),   64'd0);
                    start_v[u] = 1'b0;
                    @(posedge clk); #1;
                    check("rst_no_done", 64'(done_v[u]), 64'd0);
                    rst_n = 1'b1;
                    @(posedge clk); #1;
                    check("rst_idle_valid", 64'(valid_v[u]), 64'd0);
                    return;
                end
                rdy = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
                rdy_v[u]   = rdy;
                start_v[u] = poke_start && (k == 10);
                if (rdy) k++;
            end else begin
                check($sformatf("nk%0d_end_valid", nk), 64'(valid_v[u]), 64'd0);
                check($sformatf("nk%0d_end_busy", nk),  64'(busy_v[u]),  64'd0);
                check($sformatf("nk%0d_done", nk),      64'(done_v[u]),  64'd1);
                // Start during the done cycle must not be taken.
                start_v[u] = 1'b1;
                @(posedge clk); #1;
                start_v[u] = 1'b0;
                check($sformatf("nk%0d_done_pulse", nk), 64'(done_v[u]),  64'd0);
                check($sformatf("nk%0d_no_restart", nk), 64'(valid_v[u]), 64'd0);
                fin = 1;
            end
            if (!fin) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!fin) check($sformatf("nk%0d_timeout", nk), 64'd0, 64'd1);
    endtask

    localparam logic [255:0] K4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        rdy_v   = '0;
        key_v   = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("reset_busy%0d", u),  64'(busy_v[u]),  64'd0);
            check($sformatf("reset_valid%0d", u), 64'(valid_v[u]), 64'd0);
            check($sformatf("reset_done%0d", u),  64'(done_v[u]),  64'd0);
            check($sformatf("reset_data%0d", u),  64'(data_v[u]),  64'd0);
            check($sformatf("reset_index%0d", u), 64'(idx_v[u]),   64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_stream(0, 4, K4, 0, 0, -1);
        check("nk4_w4_const",  64'(got_w[4]),  64'h a0fafe17);
        check("nk4_w43_const", 64'(got_w[43]), 64'h b6630ca6);

        run_stream(1, 6, K6, 0, 0, -1);
        check("nk6_w6_const",  64'(got_w[6]),  64'h fe0c91f7);
        check("nk6_w51_const", 64'(got_w[51]), 64'h 01002202);

        run_stream(2, 8, K8, 0, 0, -1);
        check("nk8_w8_const",  64'(got_w[8]),  64'h 9ba35411);
        check("nk8_w12_const", 64'(got_w[12]), 64'h a8b09c1a);
        check("nk8_w59_const", 64'(got_w[59]), 64'h 706c631e);

        run_stream(0, 4, K4, 1, 0, -1);
        check("thr_w43_const", 64'(got_w[43]), 64'h b6630ca6);

        run_stream(0, 4, K4, 0, 1, 20);

        run_stream(0, 4, K4, 0, 0, -1);
        check("restart_w4_const", 64'(got_w[4]), 64'h a0fafe17);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Sequential AES key-schedule engine, parametrised for AES-128, AES-192 and AES-256 through the key length NK.
- Expands one cipher key into the full round-key word stream w[0..4·(NK+7)−1], one 32-bit word per accepted handshake.
- Generates round constants on the fly with a GF(2^8) xtime register (0x01 → … → 0x80 → 0x1b → 0x36) instead of a fixed lookup.
- Sits between the key-load interface and the round-key store/cipher datapath.

## Interface
- NK, default 4: key length in 32-bit words; legal values 4, 6, 8 (anything else is an elaboration error).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request expansion; sampled only in IDLE.
- key_in  input  32·NK  cipher key; bits [32·NK−1 -: 32] are w[0], the least-significant word is w[NK−1].
- busy  output  1  high from the start-accept cycle until the last word transfers.
- w_valid  output  1  w_data/w_index hold a word.
- w_ready  input  1  downstream accepts the word.
- w_data  output  32  round-key word, byte 0 in bits [31:24].
- w_index  output  6  index i of w_data (0..4·(NK+7)−1).
- done  output  1  one-cycle pulse in the cycle after the last transfer.

## Operation
- States: IDLE, LOAD (emit w[0..NK−1]), EXPAND (emit w[NK..]), FIN (done pulse, then IDLE).
- IDLE + start: capture key_in into an NK-word window, set rcon = 0x01, set index = 0, go to LOAD. Key changes after capture have no effect.
- Start while busy is ignored. It is not queued.
- Transfer = w_valid & w_ready. Each transfer advances index by 1.
- LOAD: w_data = window word [index]. After the transfer of w[NK−1], go to EXPAND.
- EXPAND, word i: temp = w[i−1].
  - If i mod NK = 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}. On this word's transfer, rcon ← xtime(rcon), where xtime(x) = (x<<1) ^ (x[7] ? 0x1b : 0).
  - Else if NK = 8 and i mod NK = 4: temp = SubWord(temp).
  - w[i] = w[i−NK] ^ temp.
  - On transfer, the window shifts: the oldest word drops and w[i] enters.
- RotWord rotates left by one byte. SubWord applies the AES S-box to each byte.
- After the transfer of index 4·(NK+7)−1, go to FIN.
- All arithmetic is bitwise XOR/GF(2^8); no carries.
- rcon never exceeds 0x36 for legal NK, since the last uses are 0x36 for NK=4, 0x80 for NK=6 and 0x40 for NK=8.
- Reset (any state): state = IDLE, busy = 0, w_valid = 0, done = 0, w_data = 0, w_index = 0, rcon = 0x01, window = 0. In-flight expansion is abandoned with no done pulse.

## Timing
- Outputs are registered. w_valid, w_data and w_index come from flops.
- Start accepted at edge 0 → busy = 1 and w_valid = 1 with w[0] after edge 0, i.e. one-cycle latency.
- While w_valid = 1 and w_ready = 0, w_data and w_index are held stable.
- With w_ready held high, one word per cycle and no bubbles.
- Total 4·(NK+7) transfers: 44, 52 or 60.
- Next word, including the S-box path, is computed combinationally from the window and loaded on transfer. This is a single-cycle path through aes_sbox.
- On the last transfer edge: w_valid = 0, busy = 0, done = 1 for exactly one cycle.
- A new start is accepted in the cycle done is high? No. It is accepted from the following cycle, once back in IDLE.
- w_ready while w_valid = 0 is don't-care.

## Structure
- aes_pkg (shared) holds:
  - the state enum;
  - localparam RCON_INIT = 8'h01;
  - function xtime;
  - function nwords(NK) = 4·(NK+7);
  - byte-rotation helper rot_word.
- Sub-module aes_sbox: combinational 8-bit S-box, reusable by the cipher datapath.
- One shared SubWord path of four aes_sbox instances serves both the i mod NK = 0 and NK=8 mid-key cases.

## Test plan
- NK=4, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, w_ready = 1: expect 44 words, w[4] = a0fafe17, w[43] = b6630ca6, done one cycle after w_index 43.
- NK=6, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b: expect w[6] = fe0c91f7, w[51] = 01002202.
- NK=8, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4: expect w[8] = 9ba35411, w[12] = a8b09c1a (SubWord-only word), w[59] = 706c631e.
- NK=4 with random w_ready throttling: the same 44-word sequence as the first case, w_data/w_index stable while stalled, no dropped or duplicated index.
- Start pulsed at w_index 10: ignored, stream unchanged. Then rst_n asserted at w_index 20: all outputs 0 immediately, no done. Then a new start: the stream restarts at w[0] with rcon 0x01.
